bs_decoder: RTL and testbench



---
 rtl/bs_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_bs_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_decoder.sv
// bs_decoder: receive-side USB bitstream decoder.
// Hunts for SYNC, validates the PID, deserializes token/data/handshake
// fields, steers body bits to the CRC checker and emits one registered
// good/failed pulse per end-of-packet.
module bs_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_in,
    input  logic        s_valid,
    input  logic        eop,
    input  logic        crc_ok,
    output logic [1:0]  pkt_type,
    output logic [71:0] data,
    output logic [18:0] token,
    output logic [7:0]  hshake,
    output logic        pkt_valid,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic        crc_clr,
    output logic        crc_en,
    output logic [1:0]  crc_kind,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_PID, S_BODY, S_WAIT, S_DRAIN} state_t;

    state_t      state_q, state_d, st_mid;
    logic [7:0]  win_q, win_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [6:0]  tgt_q, tgt_d;
    logic [7:0]  pid_q, pid_d;
    logic [10:0] tok_q, tok_d;
    logic [63:0] dat_q, dat_d;
    logic [1:0]  code_q, code_d;

    logic        good, bad, clr;
    logic [1:0]  bad_code;

    logic [1:0]  pkt_type_q, err_code_q, crc_kind_q;
    logic [71:0] data_q;
    logic [18:0] token_q;
    logic [7:0]  hshake_q;
    logic        pkt_valid_q, pkt_err_q, crc_clr_q, busy_q;

    // Next state: consume the bit (if any) first, then judge eop against the
    // post-bit state so a last bit arriving with eop still completes the packet.
    always_comb begin
        state_d  = state_q;
        st_mid   = state_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        pid_d    = pid_q;
        tok_d    = tok_q;
        dat_d    = dat_q;
        code_d   = code_q;
        good     = 1'b0;
        bad      = 1'b0;
        bad_code = code_q;
        clr      = 1'b0;

        if (s_valid) begin
            case (state_q)
                S_IDLE: begin
                    win_d = {win_q[6:0], s_in};
                    if (win_d == 8'h01) begin
                        st_mid = S_PID;
                        win_d  = 8'hFF;
                        cnt_d  = 7'd0;
                    end
                end
                S_PID: begin
                    pid_d = {pid_q[6:0], s_in};
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_d == 7'd8) begin
                        if (pid_d[7:4] != ~pid_d[3:0] || pid_d[1:0] == 2'b00) begin
                            code_d = 2'b01;
                            st_mid = S_DRAIN;
                        end else if (pid_d[1:0] == 2'b10) begin
                            st_mid = S_WAIT;
                        end else begin
                            clr    = 1'b1;
                            tgt_d  = (pid_d[1:0] == 2'b01) ? 7'd24 : 7'd88;
                            st_mid = S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    cnt_d = cnt_q + 7'd1;
                    // CRC bits sit after the payload; they are counted, not stored
                    if (pid_q[1:0] == 2'b01) begin
                        if (cnt_d <= 7'd19) tok_d = {tok_q[9:0], s_in};
                    end else if (cnt_d <= 7'd72) begin
                        dat_d = {dat_q[62:0], s_in};
                    end
                    if (cnt_d == tgt_q) st_mid = S_WAIT;
                end
                S_WAIT: begin
                    code_d = 2'b10;
                    st_mid = S_DRAIN;
                end
                default: ;
            endcase
        end

        state_d = st_mid;

        if (eop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            case (st_mid)
                S_PID, S_BODY: begin
                    bad      = 1'b1;
                    bad_code = 2'b10;
                end
                S_WAIT: begin
                    if (pid_d[1:0] == 2'b10 || crc_ok) begin
                        good = 1'b1;
                    end else begin
                        bad      = 1'b1;
                        bad_code = 2'b11;
                    end
                end
                S_DRAIN: begin
                    bad      = 1'b1;
                    bad_code = code_d;
                end
                default: ;
            endcase
        end

        if (state_d == S_IDLE && state_q != S_IDLE) cnt_d = 7'd0;
    end

    // Decoder state and staging registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            win_q   <= 8'hFF;
            cnt_q   <= '0;
            tgt_q   <= '0;
            pid_q   <= '0;
            tok_q   <= '0;
            dat_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            pid_q   <= pid_d;
            tok_q   <= tok_d;
            dat_q   <= dat_d;
            code_q  <= code_d;
        end
    end

    // Output registers: fields only move on a good packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_type_q  <= '0;
            data_q      <= '0;
            token_q     <= '0;
            hshake_q    <= '0;
            pkt_valid_q <= 1'b0;
            pkt_err_q   <= 1'b0;
            err_code_q  <= '0;
            crc_clr_q   <= 1'b0;
            crc_kind_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            pkt_valid_q <= good;
            pkt_err_q   <= bad;
            crc_clr_q   <= clr;
            busy_q      <= (state_d != S_IDLE);
            if (bad) err_code_q <= bad_code;
            if (clr) crc_kind_q <= pid_d[1:0];
            if (good) begin
                pkt_type_q <= pid_d[1:0];
                case (pid_d[1:0])
                    2'b10:   hshake_q <= pid_d;
                    2'b01:   token_q  <= {pid_d, tok_d};
                    default: data_q   <= {pid_d, dat_d};
                endcase
            end
        end
    end

    assign crc_en    = (state_q == S_BODY) && s_valid;
    assign pkt_type  = pkt_type_q;
    assign data      = data_q;
    assign token     = token_q;
    assign hshake    = hshake_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_err   = pkt_err_q;
    assign err_code  = err_code_q;
    assign crc_clr   = crc_clr_q;
    assign crc_kind  = crc_kind_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bs_decoder.sv
// Bench for bs_decoder: directed packets from the test plan followed by
// randomized packets, judged by a length/PID-rule reference model.
module tb_bs_decoder;

    logic        clk = 1'b0;
    logic        rst, s_in, s_valid, eop, crc_ok;
    logic [1:0]  pkt_type, err_code, crc_kind;
    logic [71:0] data;
    logic [18:0] token;
    logic [7:0]  hshake;
    logic        pkt_valid, pkt_err, crc_clr, crc_en, busy;

    bs_decoder dut (
        .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .eop(eop),
        .crc_ok(crc_ok), .pkt_type(pkt_type), .data(data), .token(token),
        .hshake(hshake), .pkt_valid(pkt_valid), .pkt_err(pkt_err),
        .err_code(err_code), .crc_clr(crc_clr), .crc_en(crc_en),
        .crc_kind(crc_kind), .busy(busy)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0, fails = 0;
    int pv_cnt, pe_cnt, clr_cnt, en_cnt;
    bit pq[$];

    // reference view of the outputs
    logic [1:0]  e_type, e_code, e_kind;
    logic [71:0] e_data;
    logic [18:0] e_token;
    logic [7:0]  e_hs;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic e, input logic c);
        s_valid = v; s_in = b; eop = e; crc_ok = c;
        #1;
        if (crc_en) en_cnt++;
        @(posedge clk); #1;
        if (crc_clr)   clr_cnt++;
        if (pkt_valid) pv_cnt++;
        if (pkt_err)   pe_cnt++;
    endtask

    task automatic gapc(input int pct);
        while ($urandom_range(0, 99) < pct) step(1'b0, 1'($urandom), 1'b0, 1'($urandom));
    endtask

    task automatic push_bits(input logic [71:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) pq.push_back(v[i]);
    endtask

    task automatic clr_counts;
        pv_cnt = 0; pe_cnt = 0; clr_cnt = 0; en_cnt = 0;
    endtask

    task automatic send_sync(input int gap);
        logic [7:0] sy;
        sy = 8'h01;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin gapc(gap); step(1'b1, sy[i], 1'b0, 1'b0); end
    endtask

    // Whole packet: SYNC, the bits in pq, then eop (with the last bit or after it)
    task automatic send(input int gap, input bit same, input logic crcok);
        clr_counts();
        send_sync(gap);
        for (int i = 0; i < pq.size(); i++) begin
            gapc(gap);
            if (same && i == pq.size() - 1) step(1'b1, pq[i], 1'b1, crcok);
            else                            step(1'b1, pq[i], 1'b0, 1'($urandom));
        end
        if (!same || pq.size() == 0) begin gapc(gap); step(1'b0, 1'b0, 1'b1, crcok); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference: outcome depends only on PID legality and total bit count after SYNC
    task automatic expect_pkt(input string tag, input logic crcok);
        int n, tgt, exp_en, exp_clr;
        logic [7:0] p;
        logic [1:0] t, code;
        bit good, pid_ok;
        n = pq.size(); p = '0;
        for (int i = 0; i < 8 && i < n; i++) p = {p[6:0], pq[i]};
        t = p[1:0];
        pid_ok = (n >= 8) && (p[7:4] == ~p[3:0]) && (t != 2'b00);
        tgt = (t == 2'b10) ? 8 : (t == 2'b01) ? 24 : 88;
        good = 1'b0; code = 2'b10;
        if (n >= 8 && !pid_ok) code = 2'b01;
        else if (pid_ok) begin
            if (n != tgt) code = 2'b10;
            else if (t == 2'b10 || crcok) good = 1'b1;
            else code = 2'b11;
        end
        exp_clr = (pid_ok && t != 2'b10) ? 1 : 0;
        exp_en  = (exp_clr == 1 && n > 8) ? (((n < tgt) ? n : tgt) - 8) : 0;
        if (exp_clr == 1) e_kind = t;
        if (good) begin
            e_type = t;
            if (t == 2'b10) e_hs = p;
            else if (t == 2'b01) begin
                e_token = {p, 11'd0};
                for (int i = 8; i < 19; i++) e_token[18 - i] = pq[i];
            end else begin
                e_data = {p, 64'd0};
                for (int i = 8; i < 72; i++) e_data[71 - i] = pq[i];
            end
        end else e_code = code;

        chk({tag, " pkt_valid"}, 72'(pv_cnt), 72'(good ? 1 : 0));
        chk({tag, " pkt_err"},   72'(pe_cnt), 72'(good ? 0 : 1));
        chk({tag, " crc_clr"},   72'(clr_cnt), 72'(exp_clr));
        chk({tag, " crc_en"},    72'(en_cnt), 72'(exp_en));
        chk({tag, " pkt_type"},  72'(pkt_type), 72'(e_type));
        chk({tag, " data"},      data, e_data);
        chk({tag, " token"},     72'(token), 72'(e_token));
        chk({tag, " hshake"},    72'(hshake), 72'(e_hs));
        chk({tag, " err_code"},  72'(err_code), 72'(e_code));
        chk({tag, " crc_kind"},  72'(crc_kind), 72'(e_kind));
        chk({tag, " busy"},      72'(busy), 72'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " pkt_type"}, 72'(pkt_type), 72'd0);
        chk({tag, " data"}, data, 72'd0);
        chk({tag, " token"}, 72'(token), 72'd0);
        chk({tag, " hshake"}, 72'(hshake), 72'd0);
        chk({tag, " pkt_valid"}, 72'(pkt_valid), 72'd0);
        chk({tag, " pkt_err"}, 72'(pkt_err), 72'd0);
        chk({tag, " err_code"}, 72'(err_code), 72'd0);
        chk({tag, " crc_clr"}, 72'(crc_clr), 72'd0);
        chk({tag, " crc_kind"}, 72'(crc_kind), 72'd0);
        chk({tag, " busy"}, 72'(busy), 72'd0);
    endtask

    initial begin
        int kind, nb, gap;
        bit same;
        logic crc;
        logic [7:0] p;
        logic [3:0] lo;

        e_type = '0; e_code = '0; e_kind = '0; e_data = '0; e_token = '0; e_hs = '0;
        rst = 1'b1; s_in = 1'b0; s_valid = 1'b0; eop = 1'b0; crc_ok = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk_zero("reset");

        // handshake ACK
        pq.delete(); push_bits(72'hD2, 8);
        send(0, 1'b0, 1'b0);
        expect_pkt("hs_D2", 1'b0);
        chk("hs_D2 const", 72'(hshake), 72'hD2);

        // token with gaps
        pq.delete(); push_bits(72'hE1, 8); push_bits(72'h2A5, 11); push_bits(72'h1B, 5);
        send(40, 1'b0, 1'b1);
        expect_pkt("tok_E1", 1'b1);
        chk("tok_E1 const", 72'(token), 72'h70AA5);

        // data, eop with the last CRC bit
        pq.delete(); push_bits(72'hC3, 8); push_bits(72'h0123456789ABCDEF, 64);
        push_bits(72'h5A3C, 16);
        send(20, 1'b1, 1'b1);
        expect_pkt("dat_C3", 1'b1);
        chk("dat_C3 const", data, 72'hC30123456789ABCDEF);

        // bad PID
        pq.delete(); push_bits(72'hD3, 8);
        send(10, 1'b0, 1'b1);
        expect_pkt("pid_D3", 1'b1);
        chk("pid_D3 code", 72'(err_code), 72'h1);

        // short data body
        pq.delete(); push_bits(72'hC3, 8); push_bits(72'hFEDCBA9876, 40);
        send(10, 1'b0, 1'b1);
        expect_pkt("short", 1'b1);
        chk("short code", 72'(err_code), 72'h2);

        // CRC failure on a token
        pq.delete(); push_bits(72'h69, 8); push_bits(72'h7FF, 11); push_bits(72'h3, 5);
        send(10, 1'b1, 1'b0);
        expect_pkt("crcbad", 1'b0);
        chk("crcbad code", 72'(err_code), 72'h3);
        chk("crcbad token kept", 72'(token), 72'h70AA5);

        // reset halfway through a data body
        clr_counts();
        send_sync(0);
        pq.delete(); push_bits(72'hC3, 8); push_bits(72'h0F0F0F0F0F, 40);
        for (int i = 0; i < pq.size(); i++) step(1'b1, pq[i], 1'b0, 1'b0);
        chk("midrst busy", 72'(busy), 72'd1);
        rst = 1'b1;
        #2;
        e_type = '0; e_code = '0; e_kind = '0; e_data = '0; e_token = '0; e_hs = '0;
        chk_zero("midrst");
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst pulses", 72'(pv_cnt + pe_cnt), 72'd0);
        pq.delete(); push_bits(72'h5A, 8);
        send(30, 1'b1, 1'b0);
        expect_pkt("hs_5A", 1'b0);

        // randomized packets
        for (int k = 0; k < 24; k++) begin
            kind = $urandom_range(0, 3);
            lo[3:2] = 2'($urandom_range(0, 3));
            lo[1:0] = (kind == 0) ? 2'b10 : (kind == 1) ? 2'b01 : 2'b11;
            p = {~lo, lo};
            if (kind == 3) p = 8'($urandom);
            nb = (p[1:0] == 2'b10) ? 0 : (p[1:0] == 2'b01) ? 16 : 80;
            if ($urandom_range(0, 3) == 0) nb = $urandom_range(0, nb + 3);
            pq.delete(); push_bits(72'(p), 8);
            for (int i = 0; i < nb; i++) pq.push_back(1'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                nb = $urandom_range(0, 7);
                while (pq.size() > nb) void'(pq.pop_back());
            end
            gap  = $urandom_range(0, 50);
            same = 1'($urandom);
            crc  = ($urandom_range(0, 3) != 0);
            send(gap, same, crc);
            expect_pkt($sformatf("rnd%0d", k), crc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
